prbs_test_sequencer: RTL and testbench

Sequencer for the PRBS link test. On `start` it transmits a 32-bit reference pattern a programmed number of times, then a fixed burst of PRBS bytes from the PRBS generator. It checks the looped-back receive stream byte-by-byte against the pattern and reports pass/fail, error count and timeout. It sits between the PRBS generator, the link transmit path and the receive-side pattern checking.

---
 rtl/prbs_test_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_prbs_test_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_test_sequencer.sv
// PRBS link test sequencer: sends a repeated 32-bit reference pattern, then a PRBS
// burst, and checks the looped-back receive stream against the pattern.
module prbs_test_sequencer #(
  parameter int PRBS_BYTES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] pattern,
  input  logic [7:0]  n_pattern,
  input  logic [7:0]  prbs_byte,
  output logic        prbs_en,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic        timeout
);

  localparam logic [11:0] PRBS_LEN = 12'(PRBS_BYTES);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_PAT,
    SEND_PRBS,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [31:0] pat_q;
  logic [7:0]  n_q;
  logic [11:0] tx_cnt;
  logic [11:0] rx_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  err_q;
  logic        timeout_q;
  logic        pass_q;

  logic [11:0] pat_len;
  logic [11:0] run_len;
  logic [11:0] rx_cnt_inc;
  logic [7:0]  tx_pat_byte;
  logic [7:0]  rx_pat_byte;
  logic [7:0]  err_n;
  logic        rx_take;
  logic        rx_mismatch;
  logic        rx_complete;
  logic        to_expire;

  assign pat_len     = {2'b00, n_q, 2'b00};
  assign run_len     = pat_len + PRBS_LEN;
  assign tx_pat_byte = pat_q[{tx_cnt[1:0], 3'b000} +: 8];
  assign rx_pat_byte = pat_q[{rx_cnt[1:0], 3'b000} +: 8];

  // Only the first 4*n received bytes are compared; later ones are just counted.
  always_comb begin
    rx_take     = rx_valid && ((state == SEND_PAT) || (state == SEND_PRBS) || (state == DRAIN));
    rx_mismatch = rx_take && (rx_cnt < pat_len) && (rx_byte != rx_pat_byte);
    err_n       = err_q;
    if (rx_mismatch && (err_q != 8'hFF)) begin
      err_n = err_q + 8'd1;
    end
    rx_cnt_inc  = rx_take ? (rx_cnt + 12'd1) : rx_cnt;
    rx_complete = (state == DRAIN) && (rx_cnt_inc >= run_len);
    to_expire   = (state == DRAIN) && !rx_valid && ((to_cnt + 16'd1) == TO_LIMIT);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (n_pattern == 8'd0) begin
            state_n = DONE;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: state_n = SEND_PAT;
      SEND_PAT: begin
        if (tx_cnt == (pat_len - 12'd1)) begin
          if (PRBS_BYTES == 0) begin
            state_n = DRAIN;
          end else begin
            state_n = SEND_PRBS;
          end
        end
      end
      SEND_PRBS: begin
        if (tx_cnt == (run_len - 12'd1)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_complete || to_expire) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Completion is tested before timeout so a final byte landing on the limit still passes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pat_q     <= '0;
      n_q       <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      to_cnt    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pat_q <= pattern;
            n_q   <= n_pattern;
            if (n_pattern == 8'd0) begin
              err_q     <= '0;
              timeout_q <= 1'b0;
              pass_q    <= 1'b0;
            end
          end
        end
        LOAD: begin
          tx_cnt    <= '0;
          rx_cnt    <= '0;
          to_cnt    <= '0;
          err_q     <= '0;
          timeout_q <= 1'b0;
          pass_q    <= 1'b0;
        end
        SEND_PAT, SEND_PRBS: begin
          tx_cnt <= tx_cnt + 12'd1;
          rx_cnt <= rx_cnt_inc;
          err_q  <= err_n;
        end
        DRAIN: begin
          rx_cnt <= rx_cnt_inc;
          err_q  <= err_n;
          if (rx_valid) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
          if (rx_complete) begin
            timeout_q <= 1'b0;
            pass_q    <= (err_n == 8'd0);
          end else if (to_expire) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      SEND_PAT:  tx_byte = tx_pat_byte;
      SEND_PRBS: tx_byte = prbs_byte;
      default:   tx_byte = 8'h00;
    endcase
  end

  assign tx_valid  = (state == SEND_PAT) || (state == SEND_PRBS);
  assign prbs_en   = (state == SEND_PRBS);
  assign busy      = (state == LOAD) || (state == SEND_PAT) || (state == SEND_PRBS) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Self-checking bench for prbs_test_sequencer: randomized runs against a
// run-level model of the expected tx stream, completion cycle and results.
module tb_prbs_test_sequencer;

  localparam int P  = 16;
  localparam int TO = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pattern = '0;
  logic [7:0]  n_pattern = '0;
  logic [7:0]  prbs_byte = '0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        prbs_en;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  int obs_done_r, tx_mismatch, ctl_mismatch, prbs_cycles, tx_cycles;
  int exp_done_r, exp_err;
  bit exp_timeout, exp_pass;
  logic [7:0] drv_prbs [0:4095];

  prbs_test_sequencer #(.PRBS_BYTES(P), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pattern(pattern), .n_pattern(n_pattern),
    .prbs_byte(prbs_byte), .prbs_en(prbs_en), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] pat_byte(input logic [31:0] pat, input int idx);
    return 8'(pat >> (8 * idx));
  endfunction

  // Byte k of the stream as the far end returns it (pattern or recorded PRBS, then impairments).
  function automatic logic [7:0] stream_byte(input logic [31:0] pat, input int k, input int pl,
                                             input int flip_idx, input bit zero_rx);
    logic [7:0] b;
    b = (k < pl) ? pat_byte(pat, k % 4) : drv_prbs[k + 2];
    if (zero_rx) b = 8'h00;
    if (k == flip_idx) b = b ^ 8'h01;
    return b;
  endfunction

  task automatic run_sequence(input logic [31:0] pat, input int n, input int delay, input int flip_idx,
                              input bit zero_rx, input int drop_tail, input int busy_start_r);
    int pl, total, m, last_rx, drain_r, budget, k;
    bit in_pat, in_prbs;
    logic [7:0] exp_byte;
    pl    = 4 * n;
    total = pl + P;
    m     = (n == 0) ? 0 : total - drop_tail;
    drain_r = total + 2;
    if (n == 0) begin
      exp_done_r = 1; exp_timeout = 0;
    end else if (m == total) begin
      exp_done_r = total + delay + 2; exp_timeout = 0;
    end else begin
      last_rx = m + 1 + delay;
      exp_done_r = (((m > 0) && (last_rx + 1 > drain_r)) ? last_rx + 1 : drain_r) + TO;
      exp_timeout = 1;
    end
    exp_err = 0;
    for (int i = 0; i < m && i < pl; i++)
      if (stream_byte(pat, i, pl, flip_idx, zero_rx) != pat_byte(pat, i % 4)) exp_err++;
    if (exp_err > 255) exp_err = 255;
    exp_pass = (n != 0) && (exp_err == 0) && !exp_timeout;

    tx_mismatch = 0; ctl_mismatch = 0; prbs_cycles = 0; tx_cycles = 0; obs_done_r = -1;
    budget = exp_done_r + 40;
    @(posedge CLK); #1;
    start = 1'b1; pattern = pat; n_pattern = 8'(n); rx_valid = 1'b0; prbs_byte = 8'($urandom);
    @(posedge CLK); #1;
    start = 1'b0; pattern = $urandom; n_pattern = 8'($urandom);
    for (int r = 1; r <= budget; r++) begin
      prbs_byte = 8'($urandom);
      drv_prbs[r] = prbs_byte;
      start = (r == busy_start_r);
      if (start) begin
        pattern = $urandom; n_pattern = 8'($urandom_range(1, 255));
      end
      k = r - delay - 2;
      if (n != 0 && k >= 0 && k < m) begin
        rx_valid = 1'b1; rx_byte = stream_byte(pat, k, pl, flip_idx, zero_rx);
      end else begin
        rx_valid = 1'b0; rx_byte = 8'($urandom);
      end
      #1;
      in_pat  = (n != 0) && (r >= 2) && (r <= 1 + pl);
      in_prbs = (n != 0) && (r >= 2 + pl) && (r <= 1 + total);
      exp_byte = in_pat ? pat_byte(pat, (r - 2) % 4) : drv_prbs[r];
      if (tx_valid !== (in_pat || in_prbs) || prbs_en !== in_prbs ||
          ((in_pat || in_prbs) && tx_byte !== exp_byte)) tx_mismatch++;
      if (busy !== (r < exp_done_r) || done !== (r >= exp_done_r)) ctl_mismatch++;
      if (tx_valid === 1'b1) tx_cycles++;
      if (prbs_en === 1'b1) prbs_cycles++;
      if (done === 1'b1) begin
        obs_done_r = r;
        break;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if ({tx_valid, prbs_en, busy, done, pass, timeout} !== 6'b0) begin n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {tx_valid, prbs_en, busy, done, pass, timeout}); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++;
      $display("[TB] FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++;
      $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if ({busy, done, tx_valid} !== 3'b000) begin n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy, done, tx_valid}); end
  endtask

  task automatic test_clean_loopback;
    run_sequence(32'hDEADBEEF, 2, 1, -1, 1'b0, 0, 0);
    n_checks++; if (tx_mismatch !== 0) begin n_fail++;
      $display("[TB] FAIL clean_tx_stream: got %0d bad cycles expected 0", tx_mismatch); end
    n_checks++; if (tx_cycles !== 24 || prbs_cycles !== 16) begin n_fail++;
      $display("[TB] FAIL clean_tx_counts: got %0d/%0d expected 24/16", tx_cycles, prbs_cycles); end
    n_checks++; if (obs_done_r !== 27 || ctl_mismatch !== 0) begin n_fail++;
      $display("[TB] FAIL clean_done_cycle: got N+%0d (%0d bad) expected N+27", obs_done_r, ctl_mismatch); end
    n_checks++; if ({pass, timeout} !== 2'b10 || err_count !== 8'd0) begin n_fail++;
      $display("[TB] FAIL clean_result: got pass=%b to=%b err=%0d expected 1 0 0", pass, timeout, err_count); end
  endtask

  task automatic test_single_bit_error;
    run_sequence(32'hDEADBEEF, 2, 1, 2, 1'b0, 0, 0);
    n_checks++; if (err_count !== 8'd1) begin n_fail++;
      $display("[TB] FAIL bit_err_count: got %0d expected 1", err_count); end
    n_checks++; if ({pass, timeout} !== 2'b00 || obs_done_r !== 27) begin n_fail++;
      $display("[TB] FAIL bit_err_result: got pass=%b to=%b done N+%0d expected 0 0 N+27", pass, timeout, obs_done_r); end
  endtask

  task automatic test_zero_count;
    run_sequence($urandom, 0, 1, -1, 1'b0, 0, 0);
    n_checks++; if (obs_done_r !== 1 || tx_cycles !== 0) begin n_fail++;
      $display("[TB] FAIL zero_count_done: got N+%0d tx=%0d expected N+1 tx=0", obs_done_r, tx_cycles); end
    n_checks++; if ({pass, timeout} !== 2'b00 || err_count !== 8'd0) begin n_fail++;
      $display("[TB] FAIL zero_count_result: got pass=%b to=%b err=%0d expected 0 0 0", pass, timeout, err_count); end
  endtask

  task automatic test_lost_bytes;
    run_sequence(32'hA5C3_0F96, 1, 3, -1, 1'b0, 2, 0);
    n_checks++; if (obs_done_r !== exp_done_r || obs_done_r !== 33) begin n_fail++;
      $display("[TB] FAIL lost_done_cycle: got N+%0d expected N+33", obs_done_r); end
    n_checks++; if ({pass, timeout} !== 2'b01 || err_count !== 8'd0) begin n_fail++;
      $display("[TB] FAIL lost_result: got pass=%b to=%b err=%0d expected 0 1 0", pass, timeout, err_count); end
  endtask

  task automatic test_saturation;
    run_sequence(32'hFFFFFFFF, 255, 1, -1, 1'b1, 0, 0);
    n_checks++; if (err_count !== 8'd255) begin n_fail++;
      $display("[TB] FAIL saturation_err: got %0d expected 255", err_count); end
    n_checks++; if ({pass, timeout} !== 2'b00 || obs_done_r !== exp_done_r) begin n_fail++;
      $display("[TB] FAIL saturation_result: got pass=%b to=%b done N+%0d expected 0 0 N+%0d",
               pass, timeout, obs_done_r, exp_done_r); end
  endtask

  task automatic test_start_while_busy;
    run_sequence($urandom, 3, 2, -1, 1'b0, 0, 5);
    n_checks++; if (tx_mismatch !== 0 || ctl_mismatch !== 0) begin n_fail++;
      $display("[TB] FAIL busy_start_ignored: got %0d/%0d bad cycles expected 0/0", tx_mismatch, ctl_mismatch); end
    n_checks++; if (pass !== 1'b1 || obs_done_r !== exp_done_r) begin n_fail++;
      $display("[TB] FAIL busy_start_result: got pass=%b done N+%0d expected 1 N+%0d", pass, obs_done_r, exp_done_r); end
  endtask

  task automatic test_reset_midrun;
    bit seen;
    seen = 0;
    @(posedge CLK); #1;
    start = 1'b1; pattern = $urandom; n_pattern = 8'd2;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      prbs_byte = 8'($urandom);
      if (prbs_en === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge CLK); #1;
    end
    n_checks++; if (!seen) begin n_fail++;
      $display("[TB] FAIL midrun_reach_prbs: got no prbs_en expected prbs_en within 50 cycles"); end
    RST = 1'b0;
    #1;
    n_checks++; if ({tx_valid, prbs_en, busy, done, pass, timeout} !== 6'b0 || tx_byte !== 8'h00 || err_count !== 8'h00) begin n_fail++;
      $display("[TB] FAIL midrun_async_clear: got flags=%b tx=%h err=%0d expected 0", 
               {tx_valid, prbs_en, busy, done, pass, timeout}, tx_byte, err_count); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if ({busy, done, tx_valid} !== 3'b000) begin n_fail++;
      $display("[TB] FAIL midrun_idle: got %b expected 000", {busy, done, tx_valid}); end
  endtask

  task automatic test_restart;
    run_sequence($urandom, 2, 1, 5, 1'b0, 0, 0);
    n_checks++; if (err_count !== 8'(exp_err) || exp_err !== 1) begin n_fail++;
      $display("[TB] FAIL restart_first_err: got %0d expected 1", err_count); end
    run_sequence($urandom, 2, 2, -1, 1'b0, 0, 0);
    n_checks++; if (err_count !== 8'd0 || pass !== 1'b1 || obs_done_r !== exp_done_r) begin n_fail++;
      $display("[TB] FAIL restart_cleared: got err=%0d pass=%b done N+%0d expected 0 1 N+%0d",
               err_count, pass, obs_done_r, exp_done_r); end
  endtask

  task automatic test_random;
    int n, dly, flip, drop;
    for (int it = 0; it < 6; it++) begin
      n    = $urandom_range(1, 8);
      dly  = $urandom_range(1, 4);
      flip = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 4 * n + P - 1);
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_sequence($urandom, n, dly, flip, 1'b0, drop, 0);
      n_checks++; if (tx_mismatch !== 0 || ctl_mismatch !== 0 || obs_done_r !== exp_done_r) begin n_fail++;
        $display("[TB] FAIL random_%0d_timing: got tx_bad=%0d ctl_bad=%0d done N+%0d expected 0 0 N+%0d",
                 it, tx_mismatch, ctl_mismatch, obs_done_r, exp_done_r); end
      n_checks++; if (err_count !== 8'(exp_err) || timeout !== exp_timeout || pass !== exp_pass) begin n_fail++;
        $display("[TB] FAIL random_%0d_result: got err=%0d to=%b pass=%b expected %0d %b %b",
                 it, err_count, timeout, pass, exp_err, exp_timeout, exp_pass); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_loopback();
    test_single_bit_error();
    test_zero_count();
    test_lost_bytes();
    test_saturation();
    test_start_while_busy();
    test_reset_midrun();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
